mult_unit: RTL

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mult_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mult_unit.sv
// mult_unit -- iterative shift-and-add multiplier for mult/multu.
//
// Signed operands are reduced to unsigned magnitudes when the operation
// starts, multiplied one multiplier bit per cycle into a 2*WIDTH-bit
// accumulator, and the sign is applied once at the end before Hi/Lo are
// written.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-high
//   MultStart  start request (mult/multu); only sampled while idle
//   MultSgn    1 = signed (mult), 0 = unsigned (multu)
//   SrcA       multiplicand (rs)
//   SrcB       multiplier (rt)
//   Hi, Lo     upper/lower half of the last completed product
//   MultBusy   high while an operation is in progress (state != IDLE)
//   MultDone   one-cycle pulse after Hi/Lo have been written
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 SIGN)
//
// Handshake: MultStart is a request qualified by !MultBusy. A request
// seen while busy is dropped, not queued. MultDone is a single-cycle
// notification with no back-pressure.
//
// Configuration
//   MULT_EARLY_TERM_EN  when defined, RUN ends as soon as the remaining
//                       multiplier bits are all zero.

module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultStart,
    input  logic             MultSgn,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             MultBusy,
    output logic             MultDone,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   mplier_sh;
    logic [2*WIDTH-1:0] acc_add;
    logic [2*WIDTH-1:0] result;
    logic               last_iter;
    logic               run_done;

    // Two's-complement magnitude; the most negative value maps to itself,
    // which is the correct unsigned magnitude.
    assign mag_a = (MultSgn && SrcA[WIDTH-1]) ? (~SrcA + WIDTH'(1)) : SrcA;
    assign mag_b = (MultSgn && SrcB[WIDTH-1]) ? (~SrcB + WIDTH'(1)) : SrcB;

    assign mplier_sh = mplier >> 1;
    assign acc_add   = mplier[0] ? (acc + mcand) : acc;
    assign result    = neg ? (~acc + (2*WIDTH)'(1)) : acc;
    assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef MULT_EARLY_TERM_EN
    // Once the shifted multiplier is zero no further additions can occur,
    // so the accumulator is already final.
    assign run_done = last_iter || (mplier_sh == '0);
`else
    assign run_done = last_iter;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (MultStart) state_nx = RUN;
            RUN:     if (run_done)  state_nx = SIGN;
            SIGN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
            MultDone <= 1'b0;
        end else begin
            MultDone <= (state == SIGN);
            case (state)
                IDLE: begin
                    if (MultStart) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        neg    <= MultSgn & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_add;
                    mcand  <= mcand << 1;
                    mplier <= mplier_sh;
                    cnt    <= cnt + CW'(1);
                end
                SIGN: begin
                    Hi <= result[2*WIDTH-1:WIDTH];
                    Lo <= result[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign MultBusy  = (state != IDLE);
    assign dbg_state = state;

endmodule
